shot_ctl: RTL and testbench

SHOT_CTL -- requirements
Module: shot_ctl

---
 rtl/shot_ctl_if.sv | 12 +
 rtl/shot_ctl.sv | 174 +++++++++++++++++
 tb/tb_shot_ctl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/shot_ctl_if.sv
// Shot link bundle between the shot controller and the opponent link:
// the outgoing shot handshake and the returning answer.
interface shot_ctl_if;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       rx_valid;
    logic       rx_hit;

    modport master (output tx_valid, tx_data, input tx_ready, rx_valid, rx_hit);
    modport slave  (input tx_valid, tx_data, output tx_ready, rx_valid, rx_hit);
endinterface

// File: rtl/shot_ctl.sv
// Own-turn shot sequencer: aim on the enemy board, send the shot, await the
// answer with timeout/resend, then record the result in the fired/hit maps.
//
// state    | meaning
// IDLE     | waiting for our turn
// AIM      | accepting clicks on the enemy board
// SEND     | offering the shot on the link
// WAIT_ANS | shot accepted, waiting for the opponent's answer
// RESULT   | one cycle, commit the answer to the maps
// WON      | all ship cells hit, sticky
// ERROR    | retries exhausted, sticky
module shot_ctl #(
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int MAX_RETRY      = 3,
    parameter int WIN_HITS       = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              turn_start,
    input  logic              click,
    input  logic [7:0]        click_pos,
    shot_ctl_if.master        link,
    output logic              shot_done,
    output logic              shot_hit,
    output logic              reject,
    output logic [99:0]       shot_map,
    output logic [99:0]       hit_map,
    output logic [4:0]        hits_cnt,
    output logic              game_won,
    output logic              link_error,
    output logic [2:0]        state_dbg
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
    localparam logic [4:0]    HITS_WIN  = 5'(WIN_HITS);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        AIM      = 3'd1,
        SEND     = 3'd2,
        WAIT_ANS = 3'd3,
        RESULT   = 3'd4,
        WON      = 3'd5,
        ERROR    = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [RW-1:0] retry_q, retry_d;
    logic        rx_hit_q, rx_hit_d;
    logic        shot_hit_q, shot_hit_d;
    logic        reject_q, reject_d;
    logic [99:0] shot_map_q, shot_map_d;
    logic [99:0] hit_map_q, hit_map_d;
    logic [4:0]  hits_q, hits_d;

    // 7-bit cell index, row*10+col tops out at 99 for on-board cells
    function automatic logic [6:0] cell_idx(input logic [7:0] pos);
        return 7'(pos[7:4]) * 7'd10 + 7'(pos[3:0]);
    endfunction

    logic [6:0] click_idx;
    logic [6:0] shot_idx;
    logic       click_ok;

    assign click_idx = cell_idx(click_pos);
    assign shot_idx  = cell_idx(tx_data_q);
    assign click_ok  = (click_pos[7:4] <= 4'd9) && (click_pos[3:0] <= 4'd9)
                       && !shot_map_q[click_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            tx_data_q  <= '0;
            tmo_q      <= '0;
            retry_q    <= '0;
            rx_hit_q   <= 1'b0;
            shot_hit_q <= 1'b0;
            reject_q   <= 1'b0;
            shot_map_q <= '0;
            hit_map_q  <= '0;
            hits_q     <= '0;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            tmo_q      <= tmo_d;
            retry_q    <= retry_d;
            rx_hit_q   <= rx_hit_d;
            shot_hit_q <= shot_hit_d;
            reject_q   <= reject_d;
            shot_map_q <= shot_map_d;
            hit_map_q  <= hit_map_d;
            hits_q     <= hits_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        tmo_d      = tmo_q;
        retry_d    = retry_q;
        rx_hit_d   = rx_hit_q;
        shot_hit_d = shot_hit_q;
        reject_d   = 1'b0;
        shot_map_d = shot_map_q;
        hit_map_d  = hit_map_q;
        hits_d     = hits_q;
        case (state_q)
            IDLE: if (turn_start) state_d = AIM;
            AIM: begin
                if (click) begin
                    if (click_ok) begin
                        tx_data_d = click_pos;
                        retry_d   = '0;
                        state_d   = SEND;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end
            SEND: begin
                if (link.tx_ready) begin
                    tmo_d   = '0;
                    state_d = WAIT_ANS;
                end
            end
            WAIT_ANS: begin
                // an answer arriving on the timeout cycle still counts
                if (link.rx_valid) begin
                    rx_hit_d = link.rx_hit;
                    state_d  = RESULT;
                end else if (tmo_q == TMO_LAST) begin
                    if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + 1'b1;
                        state_d = SEND;
                    end else begin
                        state_d = ERROR;
                    end
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            RESULT: begin
                shot_map_d[shot_idx] = 1'b1;
                shot_hit_d           = rx_hit_q;
                if (rx_hit_q) begin
                    hit_map_d[shot_idx] = 1'b1;
                    hits_d              = hits_q + 5'd1;
                end
                state_d = (hits_d == HITS_WIN) ? WON : IDLE;
            end
            WON:     state_d = WON;
            ERROR:   state_d = ERROR;
            default: state_d = IDLE;
        endcase
    end

    assign link.tx_valid = (state_q == SEND);
    assign link.tx_data  = tx_data_q;
    assign shot_done     = (state_q == RESULT);
    assign shot_hit      = shot_hit_q;
    assign reject        = reject_q;
    assign shot_map      = shot_map_q;
    assign hit_map       = hit_map_q;
    assign hits_cnt      = hits_q;
    assign game_won      = (state_q == WON);
    assign link_error    = (state_q == ERROR);
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_shot_ctl.sv
// Directed bench for shot_ctl with a short timeout and two retries.
module tb_shot_ctl;

    logic        clk = 1'b0;
    logic        rst;
    logic        turn_start;
    logic        click;
    logic [7:0]  click_pos;
    logic        shot_done;
    logic        shot_hit;
    logic        reject;
    logic [99:0] shot_map;
    logic [99:0] hit_map;
    logic [4:0]  hits_cnt;
    logic        game_won;
    logic        link_error;
    logic [2:0]  state_dbg;

    int checks = 0;
    int failures = 0;
    logic [99:0] exp_shot = '0;
    logic [99:0] exp_hit = '0;

    shot_ctl_if link ();

    shot_ctl #(.TIMEOUT_CYCLES(16), .MAX_RETRY(2), .WIN_HITS(20)) dut (
        .clk        (clk),
        .rst        (rst),
        .turn_start (turn_start),
        .click      (click),
        .click_pos  (click_pos),
        .link       (link),
        .shot_done  (shot_done),
        .shot_hit   (shot_hit),
        .reject     (reject),
        .shot_map   (shot_map),
        .hit_map    (hit_map),
        .hits_cnt   (hits_cnt),
        .game_won   (game_won),
        .link_error (link_error),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [99:0] act, input logic [99:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_turn();
        turn_start = 1'b1;
        tick();
        turn_start = 1'b0;
    endtask

    task automatic do_click(input logic [7:0] pos);
        click     = 1'b1;
        click_pos = pos;
        tick();
        click     = 1'b0;
    endtask

    function automatic int idx_of(input logic [7:0] pos);
        return int'(pos[7:4]) * 10 + int'(pos[3:0]);
    endfunction

    // Full turn with immediate accept and an answer one cycle later
    task automatic shoot(input logic [7:0] pos, input logic hit);
        pulse_turn();
        link.tx_ready = 1'b1;
        do_click(pos);
        tick();
        link.tx_ready = 1'b0;
        link.rx_valid = 1'b1;
        link.rx_hit   = hit;
        tick();
        link.rx_valid = 1'b0;
        link.rx_hit   = 1'b0;
        tick();
        exp_shot[idx_of(pos)] = 1'b1;
        if (hit) exp_hit[idx_of(pos)] = 1'b1;
    endtask

    initial begin
        int hs;
        int n;
        logic data_ok;
        logic tx_ok;

        rst = 1'b1; turn_start = 1'b0; click = 1'b0; click_pos = 8'h00;
        link.tx_ready = 1'b0; link.rx_valid = 1'b0; link.rx_hit = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check_eq("rst_state", 100'(state_dbg), 100'(0));
        check_eq("rst_txv", 100'(link.tx_valid), 100'(0));
        check_eq("rst_txd", 100'(link.tx_data), 100'(0));
        check_eq("rst_maps", shot_map | hit_map, '0);
        check_eq("rst_flags", 100'({shot_done, shot_hit, reject, game_won, link_error, hits_cnt}), 100'(0));

        // ignored inputs in IDLE
        click = 1'b1; click_pos = 8'h11; link.rx_valid = 1'b1;
        tick();
        click = 1'b0; link.rx_valid = 1'b0;
        check_eq("idle_ignore", 100'({state_dbg, reject}), 100'(0));

        // basic hit on 0x34 answered after ~10 cycles
        pulse_turn();
        check_eq("turn_aim", 100'(state_dbg), 100'(1));
        link.tx_ready = 1'b1;
        do_click(8'h34);
        check_eq("send_state", 100'(state_dbg), 100'(2));
        check_eq("send_txv", 100'(link.tx_valid), 100'(1));
        check_eq("send_txd", 100'(link.tx_data), 100'(8'h34));
        tick();
        link.tx_ready = 1'b0;
        check_eq("wait_state", 100'(state_dbg), 100'(3));
        check_eq("wait_txv", 100'(link.tx_valid), 100'(0));
        repeat (9) tick();
        link.rx_valid = 1'b1; link.rx_hit = 1'b1;
        tick();
        link.rx_valid = 1'b0; link.rx_hit = 1'b0;
        check_eq("result_done", 100'(shot_done), 100'(1));
        tick();
        exp_shot[34] = 1'b1; exp_hit[34] = 1'b1;
        check_eq("done_pulse", 100'(shot_done), 100'(0));
        check_eq("map_shot1", shot_map, exp_shot);
        check_eq("map_hit1", hit_map, exp_hit);
        check_eq("hits1", 100'(hits_cnt), 100'(1));
        check_eq("shot_hit1", 100'(shot_hit), 100'(1));
        check_eq("idle_back", 100'(state_dbg), 100'(0));

        // rejects: row out of range, col out of range, already fired
        pulse_turn();
        do_click(8'hA2);
        check_eq("rej_row", 100'({reject, link.tx_valid, state_dbg}), 100'({1'b1, 1'b0, 3'd1}));
        tick();
        check_eq("rej_pulse", 100'(reject), 100'(0));
        do_click(8'h3C);
        check_eq("rej_col", 100'({reject, link.tx_valid, state_dbg}), 100'({1'b1, 1'b0, 3'd1}));
        do_click(8'h34);
        check_eq("rej_fired", 100'({reject, link.tx_valid, state_dbg}), 100'({1'b1, 1'b0, 3'd1}));

        // back-pressure: 50 cycles with tx_ready low
        do_click(8'h55);
        tx_ok = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (!(link.tx_valid === 1'b1 && link.tx_data === 8'h55 && state_dbg === 3'd2)) tx_ok = 1'b0;
            tick();
        end
        check_eq("bp_hold", 100'(tx_ok), 100'(1));
        link.tx_ready = 1'b1;
        tick();
        link.tx_ready = 1'b0;
        check_eq("bp_wait", 100'(state_dbg), 100'(3));

        // answer on the exact timeout cycle wins
        repeat (15) tick();
        check_eq("tmo_still_wait", 100'(state_dbg), 100'(3));
        link.rx_valid = 1'b1; link.rx_hit = 1'b0;
        tick();
        link.rx_valid = 1'b0;
        check_eq("tmo_rx_result", 100'({state_dbg, link.tx_valid}), 100'({3'd4, 1'b0}));
        tick();
        exp_shot[55] = 1'b1;
        check_eq("tmo_idle", 100'({state_dbg, link.tx_valid}), 100'(0));
        check_eq("miss_shot_hit", 100'(shot_hit), 100'(0));
        check_eq("map_shot2", shot_map, exp_shot);
        check_eq("map_hit2", hit_map, exp_hit);
        check_eq("hits_miss", 100'(hits_cnt), 100'(1));

        // 18 more hits -> 19, then the winning hit
        for (int k = 0; k < 18; k++) shoot({4'(k / 10), 4'(k % 10)}, 1'b1);
        check_eq("hits19", 100'({hits_cnt, game_won, state_dbg}), 100'({5'd19, 1'b0, 3'd0}));
        shoot(8'h18, 1'b1);
        check_eq("won", 100'({hits_cnt, game_won, state_dbg}), 100'({5'd20, 1'b1, 3'd5}));
        check_eq("map_hit_won", hit_map, exp_hit);
        pulse_turn();
        tick();
        check_eq("won_sticky", 100'({game_won, state_dbg}), 100'({1'b1, 3'd5}));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("won_rst", 100'({hits_cnt, game_won, shot_hit, state_dbg, link.tx_data}), 100'(0));
        check_eq("won_rst_maps", shot_map | hit_map, '0);

        // no answer: 3 sends of the same cell, then sticky link error
        pulse_turn();
        link.tx_ready = 1'b1;
        do_click(8'h77);
        hs = 0; n = 0; data_ok = 1'b1;
        while (link_error !== 1'b1 && n < 400) begin
            if (link.tx_valid === 1'b1 && link.tx_ready === 1'b1) begin
                hs++;
                if (link.tx_data !== 8'h77) data_ok = 1'b0;
            end
            tick();
            n++;
        end
        check_eq("err_bound", 100'(n < 400), 100'(1));
        check_eq("err_sends", 100'(hs), 100'(3));
        check_eq("err_data", 100'(data_ok), 100'(1));
        link.tx_ready = 1'b0;
        pulse_turn();
        link.rx_valid = 1'b1; link.rx_hit = 1'b1;
        tick();
        link.rx_valid = 1'b0; link.rx_hit = 1'b0;
        tick();
        check_eq("err_sticky", 100'({link_error, state_dbg, link.tx_valid, shot_done}), 100'({1'b1, 3'd6, 1'b0, 1'b0}));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("err_rst", 100'({link_error, state_dbg}), 100'(0));

        // reset mid-handshake
        pulse_turn();
        do_click(8'h42);
        check_eq("mid_send", 100'(link.tx_valid), 100'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("mid_rst", 100'({link.tx_valid, state_dbg, link.tx_data}), 100'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
